// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Holds the funct3 op codes (also used by the ALU decode) and the FSM state type.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of unsigned shift-add multiply or restoring divide.
// {hi,lo} is the product accumulator when multiplying, {remainder,quotient} when dividing.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // diff[XLEN] is the borrow: the shifted remainder was smaller than the divisor
  always_comb begin
    addend  = lo[0] ? operand : '0;
    sum     = {1'b0, hi} + {1'b0, addend};
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, operand};
    if (is_div) begin
      if (diff[XLEN]) begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end else begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude arithmetic over a chain of step cells,
// sign fixup on completion, and a one-cycle bypass for divide-by-zero and signed overflow.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   count;
  logic [2:0]      op;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] result_q;
  logic            neg_main;
  logic            neg_rem;

  logic            accept;
  logic            last_step;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            div_ovf;
  logic            bypass;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] bypass_result;
  logic [XLEN-1:0] fixup_result;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  logic [XLEN-1:0] chain_hi [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] chain_lo [BITS_PER_CYCLE+1];

  // MULHSU treats src_b as unsigned; MUL's low half is sign-agnostic so it runs unsigned
  always_comb begin
    a_signed = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
               (funct3 == OP_DIV)  || (funct3 == OP_REM);
    b_signed = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
    a_neg    = a_signed && src_a[XLEN-1];
    b_neg    = b_signed && src_b[XLEN-1];
    a_mag    = a_neg ? -src_a : src_a;
    b_mag    = b_neg ? -src_b : src_b;
    div_zero = funct3[2] && (src_b == '0);
    div_ovf  = funct3[2] && b_signed && (src_a == INT_MIN) && (src_b == '1);
    bypass   = div_zero || div_ovf;
    if (div_zero) begin
      bypass_result = funct3[1] ? src_a : '1;
    end else begin
      bypass_result = funct3[1] ? '0 : src_a;
    end
  end

  assign chain_hi[0] = hi;
  assign chain_lo[0] = lo;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div  (op[2]),
      .hi      (chain_hi[i]),
      .lo      (chain_lo[i]),
      .operand (operand),
      .hi_next (chain_hi[i+1]),
      .lo_next (chain_lo[i+1])
    );
  end

  always_comb begin
    product = {chain_hi[BITS_PER_CYCLE], chain_lo[BITS_PER_CYCLE]};
    if (neg_main) begin
      product = -product;
    end
    quotient  = neg_main ? -chain_lo[BITS_PER_CYCLE] : chain_lo[BITS_PER_CYCLE];
    remainder = neg_rem  ? -chain_hi[BITS_PER_CYCLE] : chain_hi[BITS_PER_CYCLE];
    case (op)
      OP_MUL:                       fixup_result = product[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fixup_result = product[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fixup_result = quotient;
      default:                      fixup_result = remainder;
    endcase
  end

  // flush outranks both accept and result handoff
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = (count == CW'(1));
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            accept     = 1'b1;
            state_next = bypass ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (last_step) begin
            state_next = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Dividend/multiplier sits in lo and is consumed one bit per step from the appropriate end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      op       <= '0;
      hi       <= '0;
      lo       <= '0;
      operand  <= '0;
      result_q <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (accept) begin
      op       <= funct3;
      neg_main <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      count    <= CW'(ITERS);
      hi       <= '0;
      if (funct3[2]) begin
        lo      <= a_mag;
        operand <= b_mag;
      end else begin
        lo      <= b_mag;
        operand <= a_mag;
      end
      if (bypass) begin
        result_q <= bypass_result;
      end
    end else if ((state == BUSY) && !flush) begin
      hi    <= chain_hi[BITS_PER_CYCLE];
      lo    <= chain_lo[BITS_PER_CYCLE];
      count <= count - CW'(1);
      if (last_step) begin
        result_q <= fixup_result;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: one instance at 1 bit/cycle, one at 4 bits/cycle,
// checked against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc_edge;
  } exp_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [2:0]  funct3    [2];
  logic [31:0] src_a     [2];
  logic [31:0] src_b     [2];
  logic        flush     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] result    [2];
  logic        busy      [2];

  int   checks = 0;
  int   failures = 0;
  int   edges = 0;
  bit   auto_ready = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;
  logic prev_ov [2] = '{1'b0, 1'b0};
  logic [31:0] cur_exp [2] = '{32'd0, 32'd0};

  vec_t vecs [12] = '{
    '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB},
    '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000},
    '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF},
    '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
    '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
    '{OP_DIVU,   32'd100,      32'd7,        32'd14},
    '{OP_REMU,   32'd100,      32'd7,        32'd2},
    '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF},
    '{OP_REMU,   32'd5,        32'd0,        32'd5},
    '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0}
  };

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(d == 0 ? 1 : 4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[d]),
      .in_ready  (in_ready[d]),
      .funct3    (funct3[d]),
      .src_a     (src_a[d]),
      .src_b     (src_b[d]),
      .flush     (flush[d]),
      .out_valid (out_valid[d]),
      .out_ready (out_ready[d]),
      .result    (result[d]),
      .busy      (busy[d])
    );
  end

  function automatic void check_val(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut=%0d actual=%h required=%h", name, d, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    logic [63:0]     p;
    logic [31:0]     r;
    bit              ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f)
      OP_MUL:    begin p = ua * ub; r = p[31:0]; end
      OP_MULH:   begin p = sa * sb; r = p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub); r = p[63:32]; end
      OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
      OP_DIV:    begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (ovf) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      OP_DIVU:   begin p = (b == 0) ? 64'hFFFFFFFF : ua / ub; r = p[31:0]; end
      OP_REM:    begin
        if (b == 0) r = a;
        else if (ovf) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default:   begin p = (b == 0) ? ua : ua % ub; r = p[31:0]; end
    endcase
    return r;
  endfunction

  function automatic int exp_latency(int d, logic [2:0] f, logic [31:0] a, logic [31:0] b);
    bit signed_div = (f == OP_DIV) || (f == OP_REM);
    bit shortcut = f[2] && ((b == 0) || (signed_div && a == 32'h80000000 && b == 32'hFFFFFFFF));
    return shortcut ? 1 : (XLEN / (d == 0 ? 1 : 4)) + 1;
  endfunction

  task automatic apply_stimulus(int d, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                                logic [31:0] exp, bit push);
    exp_t item;
    int   waited = 0;
    @(negedge clk);
    while (!in_ready[d] && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready[d]) begin
      checks++;
      failures++;
      $display("[TB] FAIL in_ready_timeout dut=%0d actual=0 required=1", d);
      return;
    end
    in_valid[d] = 1'b1;
    funct3[d]   = f;
    src_a[d]    = a;
    src_b[d]    = b;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    if (push) begin
      item.res      = exp;
      item.lat      = exp_latency(d, f, a, b);
      item.acc_edge = edges;
      if (d == 0) q0.push_back(item);
      else q1.push_back(item);
    end
  endtask

  task automatic wait_drain(int d);
    int waited = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check_val("drain_pending", d, 32'((d == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  task automatic run_random(int d, int n);
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;
    for (int k = 0; k < n; k++) begin
      f   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) a = -32'($urandom_range(1, 1000));
      apply_stimulus(d, f, a, b, ref_model(f, a, b), 1'b1);
    end
  endtask

  // Monitor: pops the expectation when a result appears, then watches it stay put
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (out_valid[d] && !prev_ov[d]) begin
        if (((d == 0) ? q0.size() : q1.size()) == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_out_valid dut=%0d actual=1 required=0", d);
        end else begin
          if (d == 0) mon_e = q0.pop_front();
          else mon_e = q1.pop_front();
          cur_exp[d] = mon_e.res;
          check_val("result", d, result[d], mon_e.res);
          check_val("latency", d, 32'(edges - mon_e.acc_edge + 1), 32'(mon_e.lat));
        end
      end else if (out_valid[d] && prev_ov[d]) begin
        check_val("held_result", d, result[d], cur_exp[d]);
      end
      prev_ov[d] = out_valid[d];
    end
  end

  initial forever begin
    @(negedge clk);
    if (auto_ready) begin
      for (int d = 0; d < 2; d++) out_ready[d] = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      funct3[d]    = 3'd0;
      src_a[d]     = 32'd0;
      src_b[d]     = 32'd0;
      flush[d]     = 1'b0;
      out_ready[d] = 1'b1;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check_val("reset_in_ready", d, 32'(in_ready[d]), 32'd1);
      check_val("reset_out_valid", d, 32'(out_valid[d]), 32'd0);
      check_val("reset_busy", d, 32'(busy[d]), 32'd0);
      check_val("reset_result", d, result[d], 32'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) apply_stimulus(0, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, 1'b1);
    wait_drain(0);

    $display("[TB] backpressure hold");
    out_ready[0] = 1'b0;
    apply_stimulus(0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    waited = 0;
    while (!out_valid[0] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_val("hold_reached_done", 0, 32'(out_valid[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("hold_out_valid", 0, 32'(out_valid[0]), 32'd1);
      check_val("hold_in_ready", 0, 32'(in_ready[0]), 32'd0);
      check_val("hold_result", 0, result[0], 32'hFFFFFFFE);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check_val("handoff_in_ready", 0, 32'(in_ready[0]), 32'd1);
    check_val("handoff_out_valid", 0, 32'(out_valid[0]), 32'd0);

    $display("[TB] flush in BUSY");
    apply_stimulus(0, OP_DIVU, $urandom, 32'd7, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check_val("busy_before_flush", 0, 32'(busy[0]), 32'd1);
    flush[0] = 1'b1;
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    check_val("flush_busy", 0, 32'(busy[0]), 32'd0);
    check_val("flush_in_ready", 0, 32'(in_ready[0]), 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check_val("flush_no_out_valid", 0, 32'(out_valid[0]), 32'd0);
    end

    $display("[TB] flush blocks accept");
    @(negedge clk);
    in_valid[0] = 1'b1;
    funct3[0]   = OP_DIVU;
    src_b[0]    = 32'd0;
    flush[0]    = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    flush[0]    = 1'b0;
    check_val("flush_accept_busy", 0, 32'(busy[0]), 32'd0);
    check_val("flush_accept_out_valid", 0, 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    check_val("flush_accept_out_valid_later", 0, 32'(out_valid[0]), 32'd0);

    $display("[TB] reset mid BUSY");
    apply_stimulus(0, OP_MUL, $urandom, $urandom, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("midreset_busy", 0, 32'(busy[0]), 32'd0);
    check_val("midreset_in_ready", 0, 32'(in_ready[0]), 32'd1);
    check_val("midreset_out_valid", 0, 32'(out_valid[0]), 32'd0);
    check_val("midreset_result", 0, result[0], 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check_val("midreset_no_out_valid", 0, 32'(out_valid[0]), 32'd0);
    end

    $display("[TB] random mix on both instances");
    auto_ready = 1'b1;
    fork
      run_random(0, 60);
      run_random(1, 80);
    join
    wait_drain(0);
    wait_drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
